// File: rtl/rr_grant_sched_pkg.sv
// Shared types and the rotating-priority pick used by the round-robin scheduler.
package rr_grant_sched_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Scan from the highest offset down so the set bit closest to ptr wins last.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [IDX_W-1:0]   ptr);
    pick_t            r;
    logic [IDX_W-1:0] cand;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        r.found = 1'b1;
        r.idx   = cand;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_3_8.sv
// 3-to-8 one-hot decoder with enable; output is all-zero when E is low.
module decoder_3_8 (
  input  logic       E,
  input  logic [2:0] In,
  output logic [7:0] Out
);

  assign Out = E ? (8'h01 << In) : 8'h00;

endmodule

// File: rtl/rr_grant_sched.sv
// 8-requester round-robin scheduler with bounded tenure; the registered owner
// index and valid flag drive decoder_3_8 to form the one-hot grant.
module rr_grant_sched
  import rr_grant_sched_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int HOLD_W   = 8
) (
  input  logic               clka,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [IDX_W-1:0]   idx_n;
  logic               valid_n;
  logic               timeout_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_n;
  pick_t              pick;
  logic               owner_done, owner_gone, hold_max;

  assign pick       = rr_pick(req, ptr);
  assign owner_done = done[gnt_idx];
  assign owner_gone = ~req[gnt_idx];
  assign hold_max   = (hold_cnt == HOLD_W'(MAX_HOLD));

  always_ff @(posedge clka) begin
    if (rst) begin
      state     <= IDLE;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      ptr       <= '0;
      hold_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      gnt_idx   <= idx_n;
      gnt_valid <= valid_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_n;
      timeout   <= timeout_n;
    end
  end

  // Release priority: owner done, then owner withdrew, then tenure limit.
  // Only the tenure limit raises timeout, so a coincident done suppresses it.
  always_comb begin
    state_n   = state;
    idx_n     = gnt_idx;
    valid_n   = gnt_valid;
    ptr_n     = ptr;
    hold_n    = hold_cnt;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        valid_n = 1'b0;
        if (pick.found) begin
          idx_n   = pick.idx;
          valid_n = 1'b1;
          hold_n  = HOLD_W'(1);
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (owner_done || owner_gone || hold_max) begin
          valid_n   = 1'b0;
          state_n   = IDLE;
          ptr_n     = gnt_idx + IDX_W'(1);
          hold_n    = '0;
          timeout_n = ~owner_done & ~owner_gone;
        end else begin
          hold_n = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  decoder_3_8 u_decoder (
    .E   (gnt_valid),
    .In  (gnt_idx),
    .Out (gnt)
  );

endmodule

// File: tb/tb_rr_grant_sched.sv
// Directed and randomized checks of rr_grant_sched against a cycle-level
// behavioural model of the round-robin and tenure rules.
module tb_rr_grant_sched;

  localparam int MAX_HOLD = 4;

  logic       clka;
  logic       rst;
  logic [7:0] req;
  logic [7:0] done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit m_active;
  int m_last;
  int m_ptr;
  int m_held;
  bit m_timeout;

  rr_grant_sched #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (
    .clka      (clka),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial begin
    clka = 1'b0;
    forever #5 clka = ~clka;
  end

  // One clock edge of the scheduling rules, applied to the inputs seen at that edge.
  task automatic modelEdge(input logic [7:0] r, input logic [7:0] d, input logic rs);
    int cand;
    m_timeout = 1'b0;
    if (rs) begin
      m_active = 1'b0;
      m_last   = 0;
      m_ptr    = 0;
      m_held   = 0;
    end else if (!m_active) begin
      for (int k = 0; k < 8; k++) begin
        cand = (m_ptr + k) % 8;
        if (!m_active && r[cand]) begin
          m_active = 1'b1;
          m_last   = cand;
          m_held   = 1;
        end
      end
    end else if (d[m_last] || !r[m_last] || m_held == MAX_HOLD) begin
      m_timeout = !d[m_last] && r[m_last];
      m_active  = 1'b0;
      m_ptr     = (m_last + 1) % 8;
      m_held    = 0;
    end else begin
      m_held = m_held + 1;
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] exp_gnt;
    exp_gnt = m_active ? 8'(1 << m_last) : 8'h00;
    checks++;
    assert (gnt === exp_gnt) else begin
      errors++;
      $error("[TB] FAIL %s gnt: got %h expected %h", tag, gnt, exp_gnt);
    end
    checks++;
    assert (gnt_idx === 3'(m_last)) else begin
      errors++;
      $error("[TB] FAIL %s gnt_idx: got %0d expected %0d", tag, gnt_idx, m_last);
    end
    checks++;
    assert (gnt_valid === m_active) else begin
      errors++;
      $error("[TB] FAIL %s gnt_valid: got %b expected %b", tag, gnt_valid, m_active);
    end
    checks++;
    assert (timeout === m_timeout) else begin
      errors++;
      $error("[TB] FAIL %s timeout: got %b expected %b", tag, timeout, m_timeout);
    end
    checks++;
    assert ($countones(gnt) <= 1) else begin
      errors++;
      $error("[TB] FAIL %s onehot: got popcount %0d expected <=1", tag, $countones(gnt));
    end
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] d,
                               input logic rs, input string tag);
    req  = r;
    done = d;
    rst  = rs;
    @(posedge clka);
    modelEdge(r, d, rs);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [7:0] rr;
    logic [7:0] dd;
    int         k;
    bit         prev;

    req  = 8'h00;
    done = 8'h00;
    rst  = 1'b1;
    m_active = 1'b0; m_last = 0; m_ptr = 0; m_held = 0; m_timeout = 1'b0;

    // Reset and idle
    applyStimulus(8'hFF, 8'h00, 1'b1, "reset0");
    applyStimulus(8'hFF, 8'h00, 1'b1, "reset1");
    applyStimulus(8'hFF, 8'h00, 1'b0, "first_grant");
    checks++;
    assert (gnt === 8'h01 && gnt_idx === 3'd0) else begin
      errors++;
      $error("[TB] FAIL first_grant_const: got gnt=%h idx=%0d expected gnt=01 idx=0", gnt, gnt_idx);
    end

    // Rotation fairness: each owner releases one cycle after its grant
    k    = 1;
    prev = m_active;
    for (int c = 0; c < 24; c++) begin
      dd = m_active ? 8'(1 << m_last) : 8'h00;
      applyStimulus(8'hFF, dd, 1'b0, "rotate");
      if (m_active && !prev) begin
        checks++;
        assert (gnt_idx === 3'(k % 8)) else begin
          errors++;
          $error("[TB] FAIL rotate_order: got %0d expected %0d", gnt_idx, k % 8);
        end
        k++;
      end
      prev = m_active;
    end

    // Timeout: idx 2 held MAX_HOLD cycles, pulse, bubble, then idx 5
    applyStimulus(8'h24, 8'h00, 1'b1, "to_reset");
    for (int c = 0; c < 9; c++) applyStimulus(8'h24, 8'h00, 1'b0, "timeout");
    checks++;
    assert (gnt === 8'h20) else begin
      errors++;
      $error("[TB] FAIL timeout_next: got %h expected 20", gnt);
    end

    // Withdraw and wrap: ptr brought to 7, requester 7 drops after 2 cycles
    applyStimulus(8'h40, 8'h00, 1'b1, "wr_reset");
    applyStimulus(8'h40, 8'h00, 1'b0, "wr_grant6");
    applyStimulus(8'h40, 8'h40, 1'b0, "wr_rel6");
    applyStimulus(8'h81, 8'h00, 1'b0, "wr_grant7");
    applyStimulus(8'h81, 8'h00, 1'b0, "wr_hold7");
    applyStimulus(8'h01, 8'h00, 1'b0, "wr_withdraw");
    applyStimulus(8'h01, 8'h00, 1'b0, "wr_grant0");
    checks++;
    assert (gnt === 8'h01) else begin
      errors++;
      $error("[TB] FAIL wrap_grant0: got %h expected 01", gnt);
    end

    // Reset mid-grant with idx 3 requesting throughout
    applyStimulus(8'h08, 8'h00, 1'b0, "mid_idle");
    applyStimulus(8'h08, 8'h00, 1'b0, "mid_grant3");
    applyStimulus(8'h08, 8'h00, 1'b1, "mid_reset");
    applyStimulus(8'h08, 8'h00, 1'b0, "mid_regrant");

    // Non-owner done is ignored; done coinciding with tenure limit gives no timeout
    applyStimulus(8'h08, 8'hF7, 1'b0, "nonowner_done");
    for (int g = 0; g < 8 && m_active && m_held < MAX_HOLD; g++)
      applyStimulus(8'h08, 8'h00, 1'b0, "simul_hold");
    applyStimulus(8'h08, 8'h08, 1'b0, "simul_release");
    applyStimulus(8'h08, 8'h00, 1'b0, "simul_after");

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      rr = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rr = 8'h00;
      dd = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00;
      applyStimulus(rr, dd, ($urandom_range(0, 60) == 0), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
